// File: rtl/cpt_pkg.sv
// Shared constants for the cascaded modulo counter.
// Saturation mode and count direction encodings.
package cpt_pkg;
   localparam int   CPT_WRAP = 0;
   localparam int   CPT_SAT  = 1;
   localparam logic CPT_DOWN = 1'b0;
   localparam logic CPT_UP   = 1'b1;
endpackage

// File: rtl/cpt_digit.sv
// Single modulo-N counter digit with clear, clamped load and step.
// Ports: i_clk, i_nreset, i_step, i_up, i_clr, i_load, i_load_val
//        -> o_value, o_at_terminal (terminal for the current direction).
module cpt_digit
   import cpt_pkg::*;
#(
   parameter int DIGIT_WIDTH  = 4,
   parameter int DIGIT_MODULO = 10
) (
   input  logic                   i_clk,
   input  logic                   i_nreset,
   input  logic                   i_step,
   input  logic                   i_up,
   input  logic                   i_clr,
   input  logic                   i_load,
   input  logic [DIGIT_WIDTH-1:0] i_load_val,
   output logic [DIGIT_WIDTH-1:0] o_value,
   output logic                   o_at_terminal
);
   localparam logic [DIGIT_WIDTH-1:0] LP_MAX  = DIGIT_WIDTH'(DIGIT_MODULO - 1);
   localparam logic [DIGIT_WIDTH-1:0] LP_ZERO = '0;
   localparam logic [DIGIT_WIDTH-1:0] LP_ONE  = DIGIT_WIDTH'(1);

   logic [DIGIT_WIDTH-1:0] r_val;
   logic [DIGIT_WIDTH-1:0] w_next;
   logic [DIGIT_WIDTH-1:0] w_load;

   // Out-of-range load digits clamp to the largest legal digit
   assign w_load = (i_load_val > LP_MAX) ? LP_MAX : i_load_val;

   always_comb begin
      w_next = r_val;
      if (i_up == CPT_UP)
         w_next = (r_val == LP_MAX) ? LP_ZERO : r_val + LP_ONE;
      else
         w_next = (r_val == LP_ZERO) ? LP_MAX : r_val - LP_ONE;
   end

   assign o_at_terminal = (i_up == CPT_UP) ? (r_val == LP_MAX)
                                           : (r_val == LP_ZERO);
   assign o_value = r_val;

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset)
         r_val <= '0;
      else if (i_clr)
         r_val <= '0;
      else if (i_load)
         r_val <= w_load;
      else if (i_step)
         r_val <= w_next;
   end
endmodule

// File: rtl/cpt_bcd_cascade.sv
// Cascaded modulo (BCD by default) up/down counter with ripple-free carry.
// Ports: Clk, nReset, En, Up, Clr, Load, LoadVal, Latch -> Q, QLatched, Tc, Ovf.
module cpt_bcd_cascade
   import cpt_pkg::*;
#(
   parameter int NB_DIGITS    = 4,
   parameter int DIGIT_WIDTH  = 4,
   parameter int DIGIT_MODULO = 10,
   parameter int SATURATE     = 0
) (
   input  logic                             Clk,
   input  logic                             nReset,
   input  logic                             En,
   input  logic                             Up,
   input  logic                             Clr,
   input  logic                             Load,
   input  logic [NB_DIGITS*DIGIT_WIDTH-1:0] LoadVal,
   input  logic                             Latch,
   output logic [NB_DIGITS*DIGIT_WIDTH-1:0] Q,
   output logic [NB_DIGITS*DIGIT_WIDTH-1:0] QLatched,
   output logic                             Tc,
   output logic                             Ovf
);
   localparam int LP_W = NB_DIGITS * DIGIT_WIDTH;

   logic [LP_W-1:0]      w_q;
   logic [NB_DIGITS-1:0] w_term;
   logic [NB_DIGITS-1:0] w_step;
   logic [NB_DIGITS:0]   w_below;
   logic                 w_tc;
   logic                 w_hold;
   logic [LP_W-1:0]      r_qlat;
   logic                 r_ovf;

   // w_below[k]: every digit below k sits at its terminal value
   assign w_below[0] = 1'b1;
   assign w_tc       = En & w_below[NB_DIGITS];
   // In saturating mode the whole counter freezes at terminal count
   assign w_hold     = (SATURATE == CPT_SAT) & w_tc;

   for (genvar k = 0; k < NB_DIGITS; k++) begin : g_dig
      assign w_below[k+1] = w_below[k] & w_term[k];
      assign w_step[k]    = En & w_below[k] & ~w_hold;

      cpt_digit #(
         .DIGIT_WIDTH  (DIGIT_WIDTH),
         .DIGIT_MODULO (DIGIT_MODULO)
      ) u_digit (
         .i_clk         (Clk),
         .i_nreset      (nReset),
         .i_step        (w_step[k]),
         .i_up          (Up),
         .i_clr         (Clr),
         .i_load        (Load),
         .i_load_val    (LoadVal[k*DIGIT_WIDTH +: DIGIT_WIDTH]),
         .o_value       (w_q[k*DIGIT_WIDTH +: DIGIT_WIDTH]),
         .o_at_terminal (w_term[k])
      );
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_qlat <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (Latch)
            r_qlat <= w_q;
         // Clear and load override any terminal-count event
         r_ovf <= w_tc & ~Clr & ~Load;
      end
   end

   assign Q        = w_q;
   assign QLatched = r_qlat;
   assign Tc       = w_tc;
   assign Ovf      = r_ovf;
endmodule

// File: doc/cpt_bcd_cascade.md
CPT_BCD_CASCADE -- requirements
Module: cpt_bcd_cascade

Interface
REQ-001 Parameter NB_DIGITS, default 4: number of cascaded digits.
REQ-002 Parameter DIGIT_WIDTH, default 4: bits per digit.
REQ-003 Parameter DIGIT_MODULO, default 10: digit counts 0..DIGIT_MODULO-1; SHALL satisfy 2 <= DIGIT_MODULO <= 2**DIGIT_WIDTH.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at terminal value, 1 = hold at terminal value.
REQ-005 Clk  input  1: single clock; all state updates on rising edge.
REQ-006 nReset  input  1: asynchronous, active-low reset.
REQ-007 En  input  1: count enable, one step per enabled cycle.
REQ-008 Up  input  1: direction, 1 = increment, 0 = decrement.
REQ-009 Clr  input  1: synchronous clear to zero.
REQ-010 Load  input  1: synchronous load of LoadVal.
REQ-011 LoadVal  input  NB_DIGITS*DIGIT_WIDTH: value to load, digit 0 in LSBs.
REQ-012 Latch  input  1: capture live count into display register.
REQ-013 Q  output  NB_DIGITS*DIGIT_WIDTH: live count, digit 0 in LSBs.
REQ-014 QLatched  output  NB_DIGITS*DIGIT_WIDTH: last latched count.
REQ-015 Tc  output  1: combinational terminal count = En & (all digits DIGIT_MODULO-1 if Up, all digits 0 if !Up).
REQ-016 Ovf  output  1: registered one-cycle pulse, asserted the cycle after a wrap or a saturation-blocked step.

Function
REQ-017 Per-cycle priority SHALL be Clr > Load > En; with none active, Q holds.
REQ-018 Clr SHALL set every digit to 0 on the next edge regardless of Load, En, Up.
REQ-019 Load SHALL copy LoadVal into Q; any digit value >= DIGIT_MODULO SHALL be replaced by DIGIT_MODULO-1.
REQ-020 Counting SHALL be ripple-free: digit k steps iff En and all digits below k are at terminal value for the current direction (carry/borrow computed combinationally in the same cycle).
REQ-021 Up step: digit at DIGIT_MODULO-1 becomes 0, else +1; down step: digit at 0 becomes DIGIT_MODULO-1, else -1.
REQ-022 SATURATE=0: when Tc=1, whole counter wraps (all 0 up, all DIGIT_MODULO-1 down) and Ovf pulses next cycle.
REQ-023 SATURATE=1: when Tc=1, Q holds unchanged and Ovf pulses next cycle.
REQ-024 Ovf SHALL be 0 in any cycle following a Clr or Load edge, even if En and Tc were also 1.
REQ-025 Direction change SHALL take effect on the same edge Up is sampled; no pipeline delay.
REQ-026 Latch SHALL capture the value Q presents before the edge (pre-update value) into QLatched; Latch is independent of Clr/Load/En priority.
REQ-027 Latency: Q, QLatched, Ovf change exactly one edge after the controlling input is sampled; Tc is zero-latency.

Reset
REQ-028 nReset low SHALL immediately force Q=0, QLatched=0, Ovf=0, independent of Clk.
REQ-029 Release of nReset SHALL require no extra cycles; first rising edge after release obeys REQ-017.
REQ-030 Reset asserted mid-count SHALL abort the step; no partial digit update is visible.

Structure
REQ-031 Shared package cpt_pkg SHALL hold SATURATE mode constants (CPT_WRAP=0, CPT_SAT=1) and a direction constant pair (CPT_DOWN=0, CPT_UP=1).
REQ-032 One sub-module cpt_digit SHALL implement a single modulo digit (inputs step, up, clr, load, load value; outputs value, at_terminal), instantiated NB_DIGITS times by generate.
REQ-033 Carry chain, Tc, Ovf, and QLatched logic SHALL live in cpt_bcd_cascade.

Verification (NB_DIGITS=3, DIGIT_WIDTH=4, DIGIT_MODULO=10 unless stated)
REQ-034 Load 199, En=1, Up=1, one edge -> Q=200, Ovf=0; Tc=0 throughout.
REQ-035 SATURATE=0, Load 999, En=1, Up=1 -> Tc=1 before edge; after edge Q=000, next cycle Ovf=1 for exactly one cycle.
REQ-036 SATURATE=1, Load 000, En=1, Up=0 -> Q stays 000, Ovf pulses once; then Up=1 -> Q=001.
REQ-037 Clr=1, Load=1, En=1 same cycle with Q=555 -> Q=000, Ovf=0; Load with LoadVal digits F,C,3 -> Q digits 9,9,3.
REQ-038 Counting up from 040, Latch pulsed on edge where Q=042 -> QLatched=042 while Q=043.
REQ-039 nReset pulsed low between edges while Q=777, QLatched=123 -> both read 000 immediately, Ovf=0; counting resumes from 000 on first edge after release.
